// File: rtl/sm_bus_arbiter_pkg.sv
// Shared arbiter types and constants (package sm_config) for the schoolMIPS bus arbiter.
// Optional burst priority is compiled in with SM_ARB_BURST_EN.
package sm_config;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_RESP
  } sm_arb_state_t;

  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

  localparam int SM_ARB_BURST_DEFAULT = 4;

endpackage

// File: rtl/sm_bus_arbiter_pick.sv
// Combinational winner selection for the two-master bus arbiter (module sm_arb_pick).
// With SM_ARB_BURST_EN the current owner keeps ties until its burst count reaches BURST_LEN.
module sm_arb_pick
  import sm_config::*;
`ifdef SM_ARB_BURST_EN
#(
  parameter int BURST_LEN = SM_ARB_BURST_DEFAULT
)
`endif
(
  input  logic [1:0] req,
  input  logic       last_grant,
`ifdef SM_ARB_BURST_EN
  input  logic [3:0] burst_cnt,
`endif
  output logic       grant,
  output logic       valid
);

  always_comb begin
    grant = ARB_M0;
    valid = |req;
    case (req)
      2'b10: grant = ARB_M1;
      2'b11: begin
`ifdef SM_ARB_BURST_EN
        // A zero count means no burst in progress, so plain round-robin applies.
        if (burst_cnt != 4'd0 && int'(burst_cnt) < BURST_LEN) begin
          grant = last_grant;
        end else begin
          grant = ~last_grant;
        end
`else
        grant = ~last_grant;
`endif
      end
      default: grant = ARB_M0;
    endcase
  end

endmodule

// File: rtl/sm_register_we.sv
// Generic register with write enable and asynchronous active-high clear.
module sm_register_we #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/sm_bus_arbiter.sv
// Two-master round-robin arbiter driving single-cycle accesses on the schoolMIPS peripheral bus.
// Define SM_ARB_BURST_EN to let the current owner keep ties for up to BURST_LEN grants.
module sm_bus_arbiter
  import sm_config::*;
#(
  parameter int BURST_LEN = SM_ARB_BURST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0Req,
  input  logic [31:0] m0Addr,
  input  logic        m0Write,
  input  logic [31:0] m0WData,
  output logic [31:0] m0RData,
  output logic        m0Ack,
  input  logic        m1Req,
  input  logic [31:0] m1Addr,
  input  logic        m1Write,
  input  logic [31:0] m1WData,
  output logic [31:0] m1RData,
  output logic        m1Ack,
  output logic        bSel,
  output logic [31:0] bAddr,
  output logic        bWrite,
  output logic [31:0] bWData,
  input  logic [31:0] bRData
);

  if (BURST_LEN < 1 || BURST_LEN > 15) begin : g_bad_burst_len
    $error("sm_bus_arbiter: BURST_LEN must be in 1..15");
  end

  sm_arb_state_t state, state_next;

  logic        owner;
  logic        last_grant;
  logic        pick_grant;
  logic        pick_valid;
  logic        grant_en;
  logic        access_en;
  logic        sel_write;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        write_q;
  logic [31:0] rdata_q;

`ifdef SM_ARB_BURST_EN
  logic [3:0] burst_cnt;

  sm_arb_pick #(
    .BURST_LEN (BURST_LEN)
  ) u_pick (
    .req        ({m1Req, m0Req}),
    .last_grant (last_grant),
    .burst_cnt  (burst_cnt),
    .grant      (pick_grant),
    .valid      (pick_valid)
  );
`else
  sm_arb_pick u_pick (
    .req        ({m1Req, m0Req}),
    .last_grant (last_grant),
    .grant      (pick_grant),
    .valid      (pick_valid)
  );
`endif

  assign grant_en  = (state == ARB_IDLE) && pick_valid;
  assign access_en = (state == ARB_ACCESS);

  assign sel_addr  = (pick_grant == ARB_M1) ? m1Addr  : m0Addr;
  assign sel_write = (pick_grant == ARB_M1) ? m1Write : m0Write;
  assign sel_wdata = (pick_grant == ARB_M1) ? m1WData : m0WData;

  // Grant stage: winner's fields are frozen here, so later changes on its inputs are ignored.
  sm_register_we #(.WIDTH(32)) u_addr_reg (
    .clk (clk), .rst (rst), .we (grant_en), .d (sel_addr), .q (bAddr)
  );

  sm_register_we #(.WIDTH(1)) u_write_reg (
    .clk (clk), .rst (rst), .we (grant_en), .d (sel_write), .q (write_q)
  );

  sm_register_we #(.WIDTH(32)) u_wdata_reg (
    .clk (clk), .rst (rst), .we (grant_en), .d (sel_wdata), .q (bWData)
  );

  // Access stage: slave data is captured for reads and writes alike.
  sm_register_we #(.WIDTH(32)) u_rdata_reg (
    .clk (clk), .rst (rst), .we (access_en), .d (bRData), .q (rdata_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE:   if (pick_valid) state_next = ARB_ACCESS;
      ARB_ACCESS: state_next = ARB_RESP;
      ARB_RESP:   state_next = ARB_IDLE;
      default:    state_next = ARB_IDLE;
    endcase
  end

  // Last-grant starts at m1 so the first tie after reset goes to m0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner      <= ARB_M0;
      last_grant <= ARB_M1;
    end else begin
      if (grant_en) begin
        owner <= pick_grant;
      end
      if (state == ARB_RESP) begin
        last_grant <= owner;
      end
    end
  end

`ifdef SM_ARB_BURST_EN
  // A grant to the other master restarts the run at 1, counting that grant itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_cnt <= 4'd0;
    end else if (state == ARB_IDLE) begin
      if (!pick_valid) begin
        burst_cnt <= 4'd0;
      end else if (pick_grant == last_grant && burst_cnt != 4'd0) begin
        if (burst_cnt != 4'hF) begin
          burst_cnt <= burst_cnt + 4'd1;
        end
      end else begin
        burst_cnt <= 4'd1;
      end
    end
  end
`endif

  // Bus strobes decode straight from state so an asynchronous reset drops them at once.
  assign bSel    = access_en;
  assign bWrite  = access_en && write_q;

  assign m0Ack   = (state == ARB_RESP) && (owner == ARB_M0);
  assign m1Ack   = (state == ARB_RESP) && (owner == ARB_M1);
  assign m0RData = rdata_q;
  assign m1RData = rdata_q;

endmodule

// File: tb/tb_sm_bus_arbiter.sv
// Self-checking bench for sm_bus_arbiter: directed scenarios plus randomized traffic against
// a transaction-level reference model. Honors SM_ARB_BURST_EN the same way as the design.
module tb_sm_bus_arbiter;

  localparam int BURST_LEN = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0Req, m1Req, m0Write, m1Write;
  logic [31:0] m0Addr, m1Addr, m0WData, m1WData;
  logic [31:0] m0RData, m1RData;
  logic        m0Ack, m1Ack;
  logic        bSel, bWrite;
  logic [31:0] bAddr, bWData, bRData;

  int checks = 0;
  int fails  = 0;

  // Reference model state: one transaction in flight at most.
  int          cyc       = 0;
  int          next_free = 0;
  int          acc_c     = -10;
  int          ack_c     = -10;
  int          run       = 0;
  logic        last_w    = 1'b1;
  logic        tw        = 1'b0;
  logic        tww       = 1'b0;
  logic [31:0] ta        = '0;
  logic [31:0] twd       = '0;

  always #5 clk = ~clk;

  function automatic logic [31:0] slave_fn(input logic [31:0] a);
    return {a[15:0], 16'h00A5};
  endfunction

  assign bRData = bSel ? slave_fn(bAddr) : 32'hDEAD_BEEF;

  sm_bus_arbiter #(.BURST_LEN(BURST_LEN)) dut (
    .clk     (clk),
    .rst     (rst),
    .m0Req   (m0Req),
    .m0Addr  (m0Addr),
    .m0Write (m0Write),
    .m0WData (m0WData),
    .m0RData (m0RData),
    .m0Ack   (m0Ack),
    .m1Req   (m1Req),
    .m1Addr  (m1Addr),
    .m1Write (m1Write),
    .m1WData (m1WData),
    .m1RData (m1RData),
    .m1Ack   (m1Ack),
    .bSel    (bSel),
    .bAddr   (bAddr),
    .bWrite  (bWrite),
    .bWData  (bWData),
    .bRData  (bRData)
  );

  // A free arbiter grants at the end of a cycle; bus one cycle later, ack two, free again three.
  task automatic model_decide();
    logic w;
    if (cyc < next_free) return;
    if (!(m0Req || m1Req)) begin
      run = 0;
      return;
    end
    if (m0Req && m1Req) begin
`ifdef SM_ARB_BURST_EN
      w = (run >= 1 && run < BURST_LEN) ? last_w : ~last_w;
`else
      w = ~last_w;
`endif
    end else begin
      w = m1Req;
    end
    if (w == last_w && run != 0) run = (run < 15) ? run + 1 : run;
    else run = 1;
    last_w    = w;
    tw        = w;
    ta        = w ? m1Addr : m0Addr;
    tww       = w ? m1Write : m0Write;
    twd       = w ? m1WData : m0WData;
    acc_c     = cyc + 1;
    ack_c     = cyc + 2;
    next_free = cyc + 3;
  endtask

  task automatic model_reset();
    cyc = 0; next_free = 0; acc_c = -10; ack_c = -10; run = 0; last_w = 1'b1;
  endtask

  task automatic tick();
    if (!rst) model_decide();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m0Req = 1'b0; m0Addr = '0; m0Write = 1'b0; m0WData = '0;
    m1Req = 1'b0; m1Addr = '0; m1Write = 1'b0; m1WData = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m0Req = 1'b1; m0Addr = 32'h1111_0000; m0Write = 1'b1; m0WData = 32'h5555_AAAA;
    m1Req = 1'b1; m1Addr = 32'h2222_0000; m1Write = 1'b1; m1WData = 32'hAAAA_5555;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({bSel, bWrite, m0Ack, m1Ack} !== 4'b0000) begin
        fails++;
        $display("FAIL reset_ctl: {bSel,bWrite,m0Ack,m1Ack}=%b expected 0000", {bSel, bWrite, m0Ack, m1Ack});
      end
    end
    checks++;
    if ({bAddr, bWData, m0RData, m1RData} !== 128'd0) begin
      fails++;
      $display("FAIL reset_data: bAddr=%h bWData=%h m0RData=%h m1RData=%h expected all 0",
               bAddr, bWData, m0RData, m1RData);
    end
    do_reset();
  endtask

  task automatic test_single_read();
    do_reset();
    m0Req = 1'b1; m0Addr = 32'h0; m0Write = 1'b0; m0WData = 32'h1234_5678;
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        checks++;
        if (!(bSel === 1'b1 && bAddr === 32'h0 && bWrite === 1'b0)) begin
          fails++;
          $display("FAIL single_read_bus: bSel=%b bAddr=%h bWrite=%b expected 1 00000000 0", bSel, bAddr, bWrite);
        end
      end
      if (k == 2) begin
        checks++;
        if (!(m0Ack === 1'b1 && m0RData === 32'h0000_00A5)) begin
          fails++;
          $display("FAIL single_read_ack: m0Ack=%b m0RData=%h expected 1 000000a5", m0Ack, m0RData);
        end
        m0Req = 1'b0;
      end
      if (k != 1) begin
        checks++;
        if (bSel !== 1'b0) begin
          fails++;
          $display("FAIL single_read_sel: cycle %0d bSel=%b expected 0", k, bSel);
        end
      end
      checks++;
      if (m1Ack !== 1'b0) begin
        fails++;
        $display("FAIL single_read_m1ack: cycle %0d m1Ack=%b expected 0", k, m1Ack);
      end
      tick();
    end
  endtask

  task automatic test_conflict();
    logic [3:0] exp;
    do_reset();
    m0Req = 1'b1; m0Write = 1'b1; m0Addr = 32'h4; m0WData = 32'h3C;
    m1Req = 1'b1; m1Write = 1'b0; m1Addr = 32'h0; m1WData = 32'h0;
    for (int k = 0; k < 7; k++) begin
      case (k)
        1:       exp = 4'b1100;
        2:       exp = 4'b0010;
        4:       exp = 4'b1000;
        5:       exp = 4'b0001;
        default: exp = 4'b0000;
      endcase
      checks++;
      if ({bSel, bWrite, m0Ack, m1Ack} !== exp) begin
        fails++;
        $display("FAIL conflict_ctl: cycle %0d {bSel,bWrite,m0Ack,m1Ack}=%b expected %b",
                 k, {bSel, bWrite, m0Ack, m1Ack}, exp);
      end
      if (k == 1) begin
        checks++;
        if ({bAddr, bWData} !== {32'h4, 32'h3C}) begin
          fails++;
          $display("FAIL conflict_m0_bus: bAddr=%h bWData=%h expected 00000004 0000003c", bAddr, bWData);
        end
      end
      if (k == 4) begin
        checks++;
        if (bAddr !== 32'h0) begin
          fails++;
          $display("FAIL conflict_m1_bus: bAddr=%h expected 00000000", bAddr);
        end
      end
      if (k == 5) begin
        checks++;
        if (m1RData !== 32'hA5) begin
          fails++;
          $display("FAIL conflict_m1_rdata: m1RData=%h expected 000000a5", m1RData);
        end
      end
      if (k == 2) m0Req = 1'b0;
      if (k == 5) m1Req = 1'b0;
      tick();
    end
  endtask

  task automatic test_alternation();
    int seq[8];
    int n;
    int exp;
    logic [3:0] exp_ctl;
    n = 0;
    do_reset();
    m0Req = 1'b1; m0Addr = $urandom; m0Write = 1'($urandom_range(1)); m0WData = $urandom;
    m1Req = 1'b1; m1Addr = $urandom; m1Write = 1'($urandom_range(1)); m1WData = $urandom;
    for (int k = 0; k < 60 && n < 8; k++) begin
      exp_ctl = {cyc == acc_c, cyc == acc_c && tww, cyc == ack_c && !tw, cyc == ack_c && tw};
      checks++;
      if ({bSel, bWrite, m0Ack, m1Ack} !== exp_ctl) begin
        fails++;
        $display("FAIL alt_ctl: cycle %0d {bSel,bWrite,m0Ack,m1Ack}=%b expected %b",
                 cyc, {bSel, bWrite, m0Ack, m1Ack}, exp_ctl);
      end
      if (cyc == acc_c) begin
        checks++;
        if ({bAddr, bWData} !== {ta, twd}) begin
          fails++;
          $display("FAIL alt_bus: cycle %0d bAddr=%h bWData=%h expected %h %h", cyc, bAddr, bWData, ta, twd);
        end
      end
      if (m0Ack ^ m1Ack) begin
        seq[n] = int'(m1Ack);
        n++;
      end
      if (cyc == ack_c) begin
        if (tw) begin
          m1Addr = $urandom; m1Write = 1'($urandom_range(1)); m1WData = $urandom;
        end else begin
          m0Addr = $urandom; m0Write = 1'($urandom_range(1)); m0WData = $urandom;
        end
      end
      tick();
    end
    for (int i = 0; i < 8; i++) begin
`ifdef SM_ARB_BURST_EN
      exp = (i / BURST_LEN) % 2;
`else
      exp = i % 2;
`endif
      checks++;
      if (i >= n) begin
        fails++;
        $display("FAIL alt_order: transfer %0d never acknowledged, expected master %0d", i, exp);
      end else if (seq[i] != exp) begin
        fails++;
        $display("FAIL alt_order: transfer %0d granted master %0d expected master %0d", i, seq[i], exp);
      end
    end
    m0Req = 1'b0; m1Req = 1'b0;
    for (int k = 0; k < 4; k++) tick();
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_ctl;
    do_reset();
    m1Req = 1'b1; m1Write = 1'b1; m1Addr = 32'h10; m1WData = 32'h55;
    tick();
    checks++;
    if ({bSel, bWrite} !== 2'b11) begin
      fails++;
      $display("FAIL rstmid_access: bSel=%b bWrite=%b expected 1 1", bSel, bWrite);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bSel, bWrite} !== 2'b00) begin
      fails++;
      $display("FAIL rstmid_async_drop: bSel=%b bWrite=%b expected 0 0", bSel, bWrite);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({bSel, bWrite, m0Ack, m1Ack} !== 4'b0000) begin
        fails++;
        $display("FAIL rstmid_held: {bSel,bWrite,m0Ack,m1Ack}=%b expected 0000", {bSel, bWrite, m0Ack, m1Ack});
      end
    end
    rst = 1'b0;
    model_reset();
    m0Req = 1'b1; m0Write = 1'b0; m0Addr = 32'h20; m0WData = 32'h0;
    for (int k = 0; k < 7; k++) begin
      exp_ctl = {cyc == acc_c, cyc == acc_c && tww, cyc == ack_c && !tw, cyc == ack_c && tw};
      checks++;
      if ({bSel, bWrite, m0Ack, m1Ack} !== exp_ctl) begin
        fails++;
        $display("FAIL rstmid_after_ctl: cycle %0d {bSel,bWrite,m0Ack,m1Ack}=%b expected %b",
                 k, {bSel, bWrite, m0Ack, m1Ack}, exp_ctl);
      end
      if (k == 2) begin
        checks++;
        if ({m0Ack, m1Ack} !== 2'b10) begin
          fails++;
          $display("FAIL rstmid_first_tie: m0Ack=%b m1Ack=%b expected 1 0", m0Ack, m1Ack);
        end
        m0Req = 1'b0;
      end
      if (k == 5) m1Req = 1'b0;
      tick();
    end
  endtask

  task automatic test_addr_change();
    do_reset();
    m0Req = 1'b1; m0Write = 1'b0; m0Addr = 32'h20;
    m1Req = 1'b1; m1Write = 1'b0; m1Addr = 32'h8;
    for (int k = 0; k < 7; k++) begin
      if (k == 4) begin
        checks++;
        if (!(bSel === 1'b1 && bAddr === 32'hC)) begin
          fails++;
          $display("FAIL addr_change_bus: bSel=%b bAddr=%h expected 1 0000000c", bSel, bAddr);
        end
      end
      if (k == 5) begin
        checks++;
        if (!(m1Ack === 1'b1 && m1RData === slave_fn(32'hC))) begin
          fails++;
          $display("FAIL addr_change_ack: m1Ack=%b m1RData=%h expected 1 %h", m1Ack, m1RData, slave_fn(32'hC));
        end
      end
      if (k == 1) m1Addr = 32'hC;
      if (k == 2) m0Req = 1'b0;
      if (k == 5) m1Req = 1'b0;
      tick();
    end
  endtask

  task automatic test_random();
    logic [3:0] exp_ctl;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      exp_ctl = {cyc == acc_c, cyc == acc_c && tww, cyc == ack_c && !tw, cyc == ack_c && tw};
      checks++;
      if ({bSel, bWrite, m0Ack, m1Ack} !== exp_ctl) begin
        fails++;
        $display("FAIL rand_ctl: cycle %0d {bSel,bWrite,m0Ack,m1Ack}=%b expected %b",
                 cyc, {bSel, bWrite, m0Ack, m1Ack}, exp_ctl);
      end
      if (cyc == acc_c) begin
        checks++;
        if ({bAddr, bWData} !== {ta, twd}) begin
          fails++;
          $display("FAIL rand_bus: cycle %0d bAddr=%h bWData=%h expected %h %h", cyc, bAddr, bWData, ta, twd);
        end
      end
      if (cyc == ack_c) begin
        checks++;
        if ({m0RData, m1RData} !== {slave_fn(ta), slave_fn(ta)}) begin
          fails++;
          $display("FAIL rand_rdata: cycle %0d m0RData=%h m1RData=%h expected %h", cyc, m0RData, m1RData, slave_fn(ta));
        end
      end
      // Masters: finish on ack, start new work at random, wiggle fields only while ungranted.
      if (cyc == ack_c && tw == 1'b0) m0Req = 1'b0;
      else if (!m0Req) begin
        if ($urandom_range(2) == 0) begin
          m0Req = 1'b1; m0Addr = $urandom; m0Write = 1'($urandom_range(1)); m0WData = $urandom;
        end
      end else if (!(tw == 1'b0 && cyc >= acc_c && cyc <= ack_c)) begin
        if ($urandom_range(3) == 0) m0Addr = $urandom;
      end else if (cyc == acc_c && $urandom_range(15) == 0) m0Req = 1'b0;
      if (cyc == ack_c && tw == 1'b1) m1Req = 1'b0;
      else if (!m1Req) begin
        if ($urandom_range(2) == 0) begin
          m1Req = 1'b1; m1Addr = $urandom; m1Write = 1'($urandom_range(1)); m1WData = $urandom;
        end
      end else if (!(tw == 1'b1 && cyc >= acc_c && cyc <= ack_c)) begin
        if ($urandom_range(3) == 0) m1Addr = $urandom;
      end else if (cyc == acc_c && $urandom_range(15) == 0) m1Req = 1'b0;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_conflict();
    test_alternation();
    test_reset_mid();
    test_addr_change();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
